// File: rtl/router_pkg.sv
// Shared router types: packet bundle and receiver states.
// Used by rx ports, crossbar and output serialisers.
package router_pkg;

  localparam int NUM_PORTS_DEF = 8;
  localparam int DA_W = 4;
  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    PAD,
    DATA,
    DRAIN
  } rx_state_t;

  typedef struct packed {
    logic [DA_W-1:0]   da;
    logic [DATA_W-1:0] data;
  } rx_pkt_t;

endpackage

// File: rtl/router_rx_port_if.sv
// Packet handshake between an rx port and the crossbar.
// master = rx port, slave = crossbar/arbiter.
interface router_rx_port_if;
  import router_pkg::*;

  logic              pkt_valid;
  logic              pkt_ready;
  logic [DA_W-1:0]   pkt_sa;
  logic [DA_W-1:0]   pkt_da;
  logic [DATA_W-1:0] pkt_data;

  modport master (
    output pkt_valid,
    output pkt_sa,
    output pkt_da,
    output pkt_data,
    input  pkt_ready
  );

  modport slave (
    input  pkt_valid,
    input  pkt_sa,
    input  pkt_da,
    input  pkt_data,
    output pkt_ready
  );

endinterface

// File: rtl/router_pkt_fifo.sv
// Small packet FIFO; a push into a full FIFO succeeds
// when a pop happens on the same edge.
module router_pkt_fifo
  import router_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   push,
  input  rx_pkt_t                push_pkt,
  input  logic                   pop,
  output rx_pkt_t                head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  rx_pkt_t         mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_pkt;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/router_rx_port.sv
// Router input port: deserialises frame_n/valid_n/di packets,
// checks framing and queues good packets for the crossbar.
module router_rx_port
  import router_pkg::*;
#(
  parameter int PORT_ID    = 0,
  parameter int NUM_PORTS  = NUM_PORTS_DEF,
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_PAD    = 31
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             frame_n,
  input  logic             valid_n,
  input  logic             di,
  router_rx_port_if.master pkt,
  output logic             busy,
  output logic             err_pulse,
  output logic             drop_pulse,
  output logic [7:0]       rcvd_cnt
);

  localparam int PW = $clog2(MAX_PAD + 2);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DA_W:0]  NP      = (DA_W + 1)'(NUM_PORTS);
  localparam logic [PW-1:0] PAD_LIM = PW'(MAX_PAD);

  rx_state_t         state;
  rx_state_t         state_d;
  logic [4:0]        bit_cnt;
  logic [4:0]        bit_cnt_d;
  logic [PW-1:0]     pad_cnt;
  logic [PW-1:0]     pad_cnt_d;
  logic [DA_W-1:0]   da_q;
  logic [DATA_W-1:0] data_q;
  logic              armed;
  logic              da_wr;
  logic              data_wr;
  logic              err_evt;
  logic              done_evt;
  logic              push_q;
  rx_pkt_t           push_pkt;
  rx_pkt_t           head;
  logic              full;
  logic              empty;
  logic              push_ok;
  logic [CW-1:0]     count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      pad_cnt <= '0;
    end else begin
      state   <= state_d;
      bit_cnt <= bit_cnt_d;
      pad_cnt <= pad_cnt_d;
    end
  end

  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt;
    pad_cnt_d = pad_cnt;
    da_wr     = 1'b0;
    data_wr   = 1'b0;
    err_evt   = 1'b0;
    done_evt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!frame_n && armed) begin
          da_wr     = 1'b1;
          bit_cnt_d = 5'd1;
          state_d   = ADDR;
        end
      end
      ADDR: begin
        if (frame_n) begin
          err_evt = 1'b1;
          state_d = IDLE;
        end else if (!valid_n) begin
          err_evt = 1'b1;
          state_d = DRAIN;
        end else begin
          da_wr     = 1'b1;
          bit_cnt_d = bit_cnt + 5'd1;
          if (bit_cnt == 5'd3) begin
            pad_cnt_d = '0;
            state_d   = PAD;
          end
        end
      end
      PAD: begin
        if (frame_n) begin
          err_evt = 1'b1;
          state_d = IDLE;
        end else if (!valid_n) begin
          data_wr   = 1'b1;
          bit_cnt_d = 5'd1;
          state_d   = DATA;
        end else if (pad_cnt >= PAD_LIM) begin
          err_evt = 1'b1;
          state_d = DRAIN;
        end else begin
          pad_cnt_d = pad_cnt + PW'(1);
        end
      end
      DATA: begin
        if (valid_n) begin
          if (frame_n) begin
            err_evt = 1'b1;
            state_d = IDLE;
          end
        end else begin
          data_wr   = 1'b1;
          bit_cnt_d = bit_cnt + 5'd1;
          if (bit_cnt == 5'd31) begin
            if (frame_n) begin
              state_d = IDLE;
              if ({1'b0, da_q} >= NP) begin
                err_evt = 1'b1;
              end else begin
                done_evt = 1'b1;
              end
            end else begin
              err_evt = 1'b1;
              state_d = DRAIN;
            end
          end else if (frame_n) begin
            err_evt = 1'b1;
            state_d = IDLE;
          end
        end
      end
      DRAIN: begin
        if (frame_n) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Completed packet is staged so a back-to-back frame
  // can reuse the shift registers on the push edge.
  assign push_ok = push_q && (!full || (pkt.pkt_ready && !empty));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      armed      <= 1'b0;
      da_q       <= '0;
      data_q     <= '0;
      push_q     <= 1'b0;
      push_pkt   <= '0;
      err_pulse  <= 1'b0;
      drop_pulse <= 1'b0;
      rcvd_cnt   <= '0;
    end else begin
      if (frame_n) begin
        armed <= 1'b1;
      end
      if (da_wr) begin
        da_q <= {di, da_q[DA_W-1:1]};
      end
      if (data_wr) begin
        data_q <= {di, data_q[DATA_W-1:1]};
      end
      push_q <= done_evt;
      if (done_evt) begin
        push_pkt <= '{da: da_q, data: {di, data_q[DATA_W-1:1]}};
      end
      err_pulse  <= err_evt;
      drop_pulse <= push_q && !push_ok;
      if (push_ok) begin
        rcvd_cnt <= rcvd_cnt + 8'd1;
      end
    end
  end

  router_pkt_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (push_q),
    .push_pkt (push_pkt),
    .pop      (pkt.pkt_ready),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  assign pkt.pkt_valid = !empty;
  assign pkt.pkt_sa    = DA_W'(PORT_ID);
  assign pkt.pkt_da    = head.da;
  assign pkt.pkt_data  = head.data;
  assign busy          = (count == CW'(FIFO_DEPTH));

endmodule
